// File: rtl/decode_execute_reg_if.sv
// Decode/writeback inputs and execute-stage outputs of the
// decode/execute pipeline register.
interface decode_execute_reg_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     valid_D;
  logic [ADDRESS_WIDTH-1:0] rs1_D;
  logic [ADDRESS_WIDTH-1:0] rs2_D;
  logic [ADDRESS_WIDTH-1:0] rd_D;
  logic                     use_rs1_D;
  logic                     use_rs2_D;
  logic [DATA_WIDTH-1:0]    RD1_D;
  logic [DATA_WIDTH-1:0]    RD2_D;
  logic [DATA_WIDTH-1:0]    ImmExt_D;
  logic [DATA_WIDTH-1:0]    PC_D;
  logic                     RegWrite_D;
  logic                     MemRead_D;
  logic                     MemWrite_D;
  logic                     ALUSrc_D;
  logic                     Branch_D;
  logic                     Jump_D;
  logic [2:0]               ALUControl_D;

  logic                     WE3_W;
  logic [ADDRESS_WIDTH-1:0] AD3_W;
  logic [DATA_WIDTH-1:0]    WD3_W;
  logic                     flush_E;

  logic                     valid_E;
  logic [ADDRESS_WIDTH-1:0] rs1_E;
  logic [ADDRESS_WIDTH-1:0] rs2_E;
  logic [ADDRESS_WIDTH-1:0] rd_E;
  logic                     use_rs1_E;
  logic                     use_rs2_E;
  logic [DATA_WIDTH-1:0]    RD1_E;
  logic [DATA_WIDTH-1:0]    RD2_E;
  logic [DATA_WIDTH-1:0]    ImmExt_E;
  logic [DATA_WIDTH-1:0]    PC_E;
  logic                     RegWrite_E;
  logic                     MemRead_E;
  logic                     MemWrite_E;
  logic                     ALUSrc_E;
  logic                     Branch_E;
  logic                     Jump_E;
  logic [2:0]               ALUControl_E;
  logic                     stall_D;
  logic [15:0]              bubble_cnt;

  modport master (
    output valid_D, rs1_D, rs2_D, rd_D,
    output use_rs1_D, use_rs2_D,
    output RD1_D, RD2_D, ImmExt_D, PC_D,
    output RegWrite_D, MemRead_D, MemWrite_D,
    output ALUSrc_D, Branch_D, Jump_D,
    output ALUControl_D,
    output WE3_W, AD3_W, WD3_W, flush_E,
    input  valid_E, rs1_E, rs2_E, rd_E,
    input  use_rs1_E, use_rs2_E,
    input  RD1_E, RD2_E, ImmExt_E, PC_E,
    input  RegWrite_E, MemRead_E, MemWrite_E,
    input  ALUSrc_E, Branch_E, Jump_E,
    input  ALUControl_E, stall_D, bubble_cnt
  );

  modport slave (
    input  valid_D, rs1_D, rs2_D, rd_D,
    input  use_rs1_D, use_rs2_D,
    input  RD1_D, RD2_D, ImmExt_D, PC_D,
    input  RegWrite_D, MemRead_D, MemWrite_D,
    input  ALUSrc_D, Branch_D, Jump_D,
    input  ALUControl_D,
    input  WE3_W, AD3_W, WD3_W, flush_E,
    output valid_E, rs1_E, rs2_E, rd_E,
    output use_rs1_E, use_rs2_E,
    output RD1_E, RD2_E, ImmExt_E, PC_E,
    output RegWrite_E, MemRead_E, MemWrite_E,
    output ALUSrc_E, Branch_E, Jump_E,
    output ALUControl_E, stall_D, bubble_cnt
  );
endinterface

// File: rtl/decode_execute_reg.sv
// Decode/execute pipeline register with writeback bypass,
// load-use stall detection and a saturating bubble counter.
module decode_execute_reg #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  decode_execute_reg_if.slave bus
);
  typedef struct packed {
    logic                     valid;
    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic                     use1;
    logic                     use2;
    logic [DATA_WIDTH-1:0]    rd1;
    logic [DATA_WIDTH-1:0]    rd2;
    logic [DATA_WIDTH-1:0]    imm;
    logic [DATA_WIDTH-1:0]    pc;
    logic                     regwrite;
    logic                     memread;
    logic                     memwrite;
    logic                     alusrc;
    logic                     branch;
    logic                     jump;
    logic [2:0]               alu;
  } id_ex_t;

  id_ex_t                r_e;
  id_ex_t                w_load;
  logic [15:0]           r_cnt;
  logic [DATA_WIDTH-1:0] w_op1;
  logic [DATA_WIDTH-1:0] w_op2;
  logic                  w_hit1;
  logic                  w_hit2;
  logic                  w_dep;
  logic                  w_stall;
  logic                  w_bubble;

  assign w_hit1 = bus.WE3_W && (bus.AD3_W == bus.rs1_D);
  assign w_hit2 = bus.WE3_W && (bus.AD3_W == bus.rs2_D);

  // x0 check comes first so a write to x0 is never forwarded
  always_comb begin
    w_op1 = '0;
    priority case (1'b1)
      (bus.rs1_D == '0): w_op1 = '0;
      w_hit1:            w_op1 = bus.WD3_W;
      default:           w_op1 = bus.RD1_D;
    endcase
  end

  always_comb begin
    w_op2 = '0;
    priority case (1'b1)
      (bus.rs2_D == '0): w_op2 = '0;
      w_hit2:            w_op2 = bus.WD3_W;
      default:           w_op2 = bus.RD2_D;
    endcase
  end

  assign w_dep = (bus.use_rs1_D && bus.rs1_D == r_e.rd)
              || (bus.use_rs2_D && bus.rs2_D == r_e.rd);

  assign w_stall = r_e.valid && r_e.memread
                && r_e.regwrite && (r_e.rd != '0)
                && w_dep && bus.valid_D && !bus.flush_E;

  assign w_bubble = bus.flush_E || w_stall;

  always_comb begin
    w_load       = '0;
    w_load.valid = bus.valid_D;
    w_load.rs1   = bus.rs1_D;
    w_load.rs2   = bus.rs2_D;
    w_load.rd    = bus.rd_D;
    w_load.use1  = bus.use_rs1_D;
    w_load.use2  = bus.use_rs2_D;
    w_load.rd1   = w_op1;
    w_load.rd2   = w_op2;
    w_load.imm   = bus.ImmExt_D;
    w_load.pc    = bus.PC_D;
    w_load.alu   = bus.ALUControl_D;
    if (bus.valid_D) begin
      w_load.regwrite = bus.RegWrite_D;
      w_load.memread  = bus.MemRead_D;
      w_load.memwrite = bus.MemWrite_D;
      w_load.alusrc   = bus.ALUSrc_D;
      w_load.branch   = bus.Branch_D;
      w_load.jump     = bus.Jump_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e   <= '0;
      r_cnt <= '0;
    end else begin
      r_e <= w_bubble ? '0 : w_load;
      if (w_bubble && r_cnt != 16'hFFFF)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.valid_E      = r_e.valid;
  assign bus.rs1_E        = r_e.rs1;
  assign bus.rs2_E        = r_e.rs2;
  assign bus.rd_E         = r_e.rd;
  assign bus.use_rs1_E    = r_e.use1;
  assign bus.use_rs2_E    = r_e.use2;
  assign bus.RD1_E        = r_e.rd1;
  assign bus.RD2_E        = r_e.rd2;
  assign bus.ImmExt_E     = r_e.imm;
  assign bus.PC_E         = r_e.pc;
  assign bus.RegWrite_E   = r_e.regwrite;
  assign bus.MemRead_E    = r_e.memread;
  assign bus.MemWrite_E   = r_e.memwrite;
  assign bus.ALUSrc_E     = r_e.alusrc;
  assign bus.Branch_E     = r_e.branch;
  assign bus.Jump_E       = r_e.jump;
  assign bus.ALUControl_E = r_e.alu;
  assign bus.stall_D      = w_stall;
  assign bus.bubble_cnt   = r_cnt;
endmodule
